// File: rtl/mult_seq_engine.sv
// Sequential signed 16x16 -> 32 multiply engine: reads operand pairs from a
// byte-wide data memory, multiplies by shift-add, writes big-endian products back.
module mult_seq_engine #(
  parameter int NUM_PAIRS = 16,
  parameter int OP_BASE   = 0,
  parameter int RES_BASE  = 64,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);

  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ARMED,
    S_RD0, S_RD1, S_RD2, S_RD3,
    S_MUL, S_FIX,
    S_WR0, S_WR1, S_WR2, S_WR3,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     pair;
  logic [15:0]       op_a;
  logic [7:0]        op_b_hi;
  logic [15:0]       op_b;
  logic              neg;
  logic [31:0]       mcand;
  logic [31:0]       acc;
  logic [16:0]       mplier;
  logic [3:0]        cnt;
  logic [16:0]       mag_a;
  logic [16:0]       mag_b;
  logic [ADDR_W-1:0] pair_off;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] wr_base;
  logic              last_pair;

  // 17-bit magnitude so that |-32768| = 32768 is representable.
  function automatic logic [16:0] mag17(input logic [15:0] v);
    logic [16:0] ext;
    ext = {v[15], v};
    return v[15] ? (17'd0 - ext) : ext;
  endfunction

  assign op_b      = {op_b_hi, mem_rd_data};
  assign mag_a     = mag17(op_a);
  assign mag_b     = mag17(op_b);
  assign pair_off  = ADDR_W'({pair, 2'b00});
  assign rd_base   = ADDR_W'(OP_BASE) + pair_off;
  assign wr_base   = ADDR_W'(RES_BASE) + pair_off;
  assign last_pair = (pair == PW'(NUM_PAIRS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode straight from state, so an async reset clears them at once.
  always_comb begin
    // NOTE: every output gets a default first; any path leaving one unassigned
    // would infer a latch.
    state_nxt   = state;
    done        = 1'b0;
    busy        = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ARMED;
      S_ARMED: if (!start) state_nxt = S_RD0;
      S_RD0: begin busy = 1'b1; mem_addr = rd_base;                  state_nxt = S_RD1; end
      S_RD1: begin busy = 1'b1; mem_addr = rd_base + ADDR_W'(1);     state_nxt = S_RD2; end
      S_RD2: begin busy = 1'b1; mem_addr = rd_base + ADDR_W'(2);     state_nxt = S_RD3; end
      S_RD3: begin busy = 1'b1; mem_addr = rd_base + ADDR_W'(3);     state_nxt = S_MUL; end
      S_MUL: begin
        busy = 1'b1;
        if (cnt == 4'd15) state_nxt = S_FIX;
      end
      S_FIX: begin busy = 1'b1; state_nxt = S_WR0; end
      S_WR0: begin
        busy = 1'b1; mem_wr_en = 1'b1;
        mem_addr = wr_base;                  mem_wr_data = acc[31:24]; state_nxt = S_WR1;
      end
      S_WR1: begin
        busy = 1'b1; mem_wr_en = 1'b1;
        mem_addr = wr_base + ADDR_W'(1);     mem_wr_data = acc[23:16]; state_nxt = S_WR2;
      end
      S_WR2: begin
        busy = 1'b1; mem_wr_en = 1'b1;
        mem_addr = wr_base + ADDR_W'(2);     mem_wr_data = acc[15:8];  state_nxt = S_WR3;
      end
      S_WR3: begin
        busy = 1'b1; mem_wr_en = 1'b1;
        mem_addr = wr_base + ADDR_W'(3);     mem_wr_data = acc[7:0];
        state_nxt = last_pair ? S_DONE : S_RD0;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_ARMED;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A new request while running abandons the run.
    if (busy && start) state_nxt = S_ARMED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair    <= '0;
      op_a    <= '0;
      op_b_hi <= '0;
      neg     <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_ARMED: pair <= '0;
        S_RD0:   op_a[15:8] <= mem_rd_data;
        S_RD1:   op_a[7:0]  <= mem_rd_data;
        S_RD2:   op_b_hi    <= mem_rd_data;
        S_RD3: begin
          mcand  <= {15'd0, mag_a};
          mplier <= mag_b;
          acc    <= '0;
          cnt    <= '0;
          neg    <= op_a[15] ^ op_b_hi[7];
        end
        // Fixed 16 iterations; magnitudes never exceed 2^15, so bit 16 of mplier is always 0.
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
        end
        S_FIX: if (neg) acc <= 32'd0 - acc;
        S_WR3: pair <= pair + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_engine.sv
// Self-checking bench for mult_seq_engine: byte memory model, scoreboard of
// expected products checked as each 4-byte product is written.
module tb_mult_seq_engine;

  logic       clk;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  mult_seq_engine #(
    .NUM_PAIRS(16), .OP_BASE(0), .RES_BASE(64), .ADDR_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:255];
  logic [7:0]  img [0:255];
  logic [15:0] ops [0:31];

  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] = mem_wr_data;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] prod;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b);
    int pa, pb;
    pa = int'($signed(a));
    pb = int'($signed(b));
    return 32'(pb * pa);
  endfunction

  task automatic set_op(input int i, input logic [15:0] v);
    ops[i]       = v;
    mem[2*i]     = v[15:8];
    mem[2*i+1]   = v[7:0];
    img[2*i]     = v[15:8];
    img[2*i+1]   = v[7:0];
  endtask

  task automatic push_expected(input int n);
    for (int j = 0; j < n; j++) begin
      exp_t e;
      e.addr = 8'(64 + 4*j);
      e.prod = golden(ops[2*j], ops[2*j+1]);
      sb_q.push_back(e);
      img[64+4*j]   = e.prod[31:24];
      img[64+4*j+1] = e.prod[23:16];
      img[64+4*j+2] = e.prod[15:8];
      img[64+4*j+3] = e.prod[7:0];
    end
  endtask

  function automatic logic [31:0] rd_prod(input int j);
    return {mem[64+4*j], mem[64+4*j+1], mem[64+4*j+2], mem[64+4*j+3]};
  endfunction

  task automatic check_image(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) nbad++;
    check(tag, 32'(nbad), 32'd0);
  endtask

  // Returns just after edge E0 (the edge that samples start low in ARMED).
  task automatic start_run();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check("armed_done", 32'(done), 32'd0);
    check("armed_busy", 32'(busy), 32'd0);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_done();
    repeat (399) @(posedge clk);
    #1;
    check("done_early", 32'(done), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_400", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Write monitor: assemble each 4-byte product and compare with the scoreboard head.
  int          wr_cnt = 0;
  logic [7:0]  wr_addr;
  logic [31:0] wr_word;
  exp_t        wr_exp;
  always @(negedge clk) begin
    if (reset) begin
      wr_cnt = 0;
    end else if (mem_wr_en) begin
      if (wr_cnt == 0) wr_addr = mem_addr;
      check("byte_addr", 32'(mem_addr), 32'(wr_addr + 8'(wr_cnt)));
      wr_word = {wr_word[23:0], mem_wr_data};
      wr_cnt++;
      if (wr_cnt == 4) begin
        wr_cnt = 0;
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          wr_exp = sb_q.pop_front();
          check("prod", wr_word, wr_exp.prod);
          check("prod_addr", 32'(wr_addr), 32'(wr_exp.addr));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      img[i] = mem[i];
    end
    #1;
    check("rst_outs", {19'd0, done, busy, mem_wr_en, mem_addr, mem_wr_data}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed pairs, including the extreme-magnitude and zero cases.
    set_op(0, 16'd5);      set_op(1, 16'd3);
    set_op(2, 16'd1);      set_op(3, 16'hFFFF);
    set_op(4, 16'h8000);   set_op(5, 16'h8000);
    set_op(6, 16'h8000);   set_op(7, 16'h7FFF);
    set_op(8, 16'h0000);   set_op(9, 16'hFFF9);
    for (int i = 10; i < 32; i++) set_op(i, 16'($urandom));
    push_expected(16);
    start_run();
    wait_done();
    check("p0_5x3",    rd_prod(0), 32'h0000_000F);
    check("p1_1xm1",   rd_prod(1), 32'hFFFF_FFFF);
    check("p2_minmin", rd_prod(2), 32'h4000_0000);
    check("p3_minmax", rd_prod(3), 32'hC000_8000);
    check("p4_zero",   rd_prod(4), 32'h0000_0000);
    check_image("img_directed");

    // Random pairs, two back-to-back runs from DONE.
    for (int i = 0; i < 32; i++) set_op(i, 16'($urandom));
    for (int r = 0; r < 2; r++) begin
      push_expected(16);
      start_run();
      wait_done();
      check_image("img_random");
    end

    // Abort: start sampled high at E0+130 (pair 5 in MUL).
    for (int i = 0; i < 32; i++) set_op(i, 16'($urandom));
    push_expected(5);
    start_run();
    repeat (129) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_hold", {30'd0, done, busy}, 32'd0);
    check("abort_sb", 32'(sb_q.size()), 32'd0);
    check_image("img_abort");

    // Async reset at E0+60, then a clean run.
    for (int i = 0; i < 32; i++) set_op(i, 16'($urandom));
    push_expected(2);
    start_run();
    repeat (60) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_outs", {19'd0, done, busy, mem_wr_en, mem_addr, mem_wr_data}, 32'd0);
    check("midrst_sb", 32'(sb_q.size()), 32'd0);
    check_image("img_reset");
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_done", 32'(done), 32'd0);
    push_expected(16);
    start_run();
    wait_done();
    check_image("img_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
